// File: rtl/matrix_mult_pkg.sv
// Shared types and arithmetic helpers for the matrix-mult wrapper datapath.
package matrix_mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Signed add of two w-bit values (zero-extended into 32 bits); optional clamp to w-bit range.
  function automatic logic [31:0] add_elem(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w, input logic sat);
    logic signed [31:0] sa, sb, sum, hi, lo;
    int unsigned sh;
    sh  = 32 - w;
    sa  = $signed(a << sh) >>> sh;
    sb  = $signed(b << sh) >>> sh;
    sum = sa + sb;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sat) begin
      if (sum > hi) sum = hi;
      else if (sum < lo) sum = lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length register delay line; DEPTH = 0 degenerates to a wire.
module skew_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 0
) (
  input  logic             clk_i,
  input  logic             rstn_async_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = clk_i ^ rstn_async_i;
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] stage [DEPTH];
    always_ff @(posedge clk_i or negedge rstn_async_i) begin
      if (!rstn_async_i) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end
    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/output_deskew_writer.sv
// Realigns skewed systolic-array columns into rows, optionally adds a psum row, writes the output buffer.
// Build option: OUTPUT_SATURATE_EN makes the accumulate add saturate instead of wrap.
module output_deskew_writer
  import matrix_mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned COL    = 4,
  parameter int unsigned O_SIZE = 512,
  parameter int unsigned AW     = $clog2(O_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rstn_async_i,
  input  logic                 start_i,
  input  logic [AW-1:0]        o_rows_i,
  input  logic [AW-1:0]        o_offset_i,
  input  logic [AW-1:0]        psum_offset_i,
  input  logic                 accum_en_i,
  input  logic [COL-1:0]       array_valid_i,
  input  logic [COL*WIDTH-1:0] array_data_i,
  output logic                 ps_mem_cenb_o,
  output logic                 ps_mem_wenb_o,
  output logic [AW-1:0]        ps_mem_addr_o,
  input  logic [COL*WIDTH-1:0] ps_mem_data_i,
  output logic                 ob_mem_cenb_o,
  output logic                 ob_mem_wenb_o,
  output logic [AW-1:0]        ob_mem_addr_o,
  output logic [COL*WIDTH-1:0] ob_mem_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 skew_err_o
);

`ifdef OUTPUT_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  state_t               state, state_nxt;
  logic [AW-1:0]        rows, o_off, ps_off, r;
  logic                 accum;
  logic [WIDTH:0]       dq [COL];
  logic [COL-1:0]       dv;
  logic [COL*WIDTH-1:0] row_c, s1_row, s2_row;
  logic [AW-1:0]        s1_idx, s2_idx;
  logic                 s1_valid, s2_valid;
  logic                 start_ok, accept, row_hit, skew_c, drop_c, stray_c;

  // Column c waits COL-1-c cycles so every column lines up with the last one.
  for (genvar c = 0; c < int'(COL); c++) begin : g_col
    skew_delay_line #(.WIDTH(WIDTH + 1), .DEPTH(COL - 1 - c)) u_dl (
      .clk_i       (clk_i),
      .rstn_async_i(rstn_async_i),
      .d           ({array_valid_i[c], array_data_i[c*WIDTH +: WIDTH]}),
      .q           (dq[c])
    );
  end

  always_comb begin
    dv    = '0;
    row_c = '0;
    for (int c = 0; c < int'(COL); c++) begin
      dv[c]                  = dq[c][WIDTH];
      row_c[c*WIDTH +: WIDTH] = dq[c][WIDTH-1:0];
    end
  end

  assign row_hit  = dv[COL-1];
  assign start_ok = (state == IDLE) && start_i;
  assign accept   = (state == RUN) && row_hit && (r < rows);
  assign skew_c   = (dv != '0) && (dv != '1);
  assign drop_c   = row_hit && !accept;
  assign stray_c  = (|array_valid_i) && (state != RUN);
  assign s2_valid = !ob_mem_cenb_o;

  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) state_nxt = (o_rows_i == '0) ? DONE : RUN;
      RUN:  if (s2_valid && (s2_idx == rows - AW'(1))) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, row counter and the two-stage write pipeline.
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      rows          <= '0;
      o_off         <= '0;
      ps_off        <= '0;
      accum         <= 1'b0;
      r             <= '0;
      s1_valid      <= 1'b0;
      s1_row        <= '0;
      s1_idx        <= '0;
      s2_row        <= '0;
      s2_idx        <= '0;
      ps_mem_cenb_o <= 1'b1;
      ps_mem_addr_o <= '0;
      ob_mem_cenb_o <= 1'b1;
      ob_mem_wenb_o <= 1'b1;
      ob_mem_addr_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      skew_err_o    <= 1'b0;
    end else begin
      if (start_ok) begin
        rows   <= o_rows_i;
        o_off  <= o_offset_i;
        ps_off <= psum_offset_i;
        accum  <= accum_en_i;
        r      <= '0;
      end else if (accept) begin
        r <= r + AW'(1);
      end
      s1_valid <= accept;
      if (accept) begin
        s1_row <= row_c;
        s1_idx <= r;
      end
      ps_mem_cenb_o <= !(accept && accum);
      if (accept && accum) ps_mem_addr_o <= ps_off + r;
      ob_mem_cenb_o <= !s1_valid;
      ob_mem_wenb_o <= !s1_valid;
      if (s1_valid) begin
        ob_mem_addr_o <= o_off + s1_idx;
        s2_row        <= s1_row;
        s2_idx        <= s1_idx;
      end
      busy_o <= (state_nxt == RUN);
      done_o <= (state_nxt == DONE);
      if (skew_c || drop_c || stray_c) skew_err_o <= 1'b1;
      else if (start_ok)               skew_err_o <= 1'b0;
    end
  end

  assign ps_mem_wenb_o = 1'b1;

  // Psum data returns in the write cycle, so the add sits combinationally in front of the write port.
  always_comb begin
    ob_mem_data_o = '0;
    if (s2_valid) begin
      for (int c = 0; c < int'(COL); c++) begin
        if (accum)
          ob_mem_data_o[c*WIDTH +: WIDTH] = WIDTH'(add_elem(32'(s2_row[c*WIDTH +: WIDTH]),
                                                            32'(ps_mem_data_i[c*WIDTH +: WIDTH]),
                                                            WIDTH, SAT));
        else
          ob_mem_data_o[c*WIDTH +: WIDTH] = s2_row[c*WIDTH +: WIDTH];
      end
    end
  end

endmodule
